bin_image_loader: RTL and testbench

- Writer side of the binary-image input SRAM format that the 3x3 XNOR convolution accelerator reads.
- Accepts a command stream (one image dimension per command) and a 1-bit pixel stream, both valid/ready.
- Packs each image row into one 16-bit word and writes it to the input SRAM in this layout: dimension word, then N row words, repeated per image, closed by terminator word 0x00FF.
- Used by the host/testbench loader to populate input SRAM before dut_run.

---
 rtl/bin_image_loader_pkg.sv | 38 +++
 rtl/bil_row_packer.sv | 64 ++++++
 rtl/bin_image_loader.sv | 157 +++++++++++++++
 tb/tb_bin_image_loader.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bin_image_loader_pkg.sv
// Shared constants, state encoding and helpers for the binary-image SRAM loader.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   ADDR_W_DEF / DATA_W_DEF / TERM_WORD_DEF : default geometry of the input SRAM
//   DIM_W                                   : width of the command dimension field
//   DIM_10 / DIM_12 / DIM_16                : the only image sizes the accelerator reads
//   state_t                                 : one-hot loader FSM encoding
package bin_image_loader_pkg;

  localparam int          ADDR_W_DEF    = 12;
  localparam int          DATA_W_DEF    = 16;
  localparam int          DIM_W         = 5;
  localparam logic [15:0] TERM_WORD_DEF = 16'h00FF;

  localparam logic [DIM_W-1:0] DIM_10 = 5'd10;
  localparam logic [DIM_W-1:0] DIM_12 = 5'd12;
  localparam logic [DIM_W-1:0] DIM_16 = 5'd16;

  // One-hot bit positions, so output decodes are a single flop bit each.
  localparam int IDLE_B = 0;
  localparam int CMD_B  = 1;
  localparam int ROW_B  = 2;
  localparam int FIN_B  = 3;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_CMD  = 4'b0010,
    ST_ROW  = 4'b0100,
    ST_FIN  = 4'b1000
  } state_t;

  function automatic logic dim_legal(input logic [DIM_W-1:0] d);
    return (d == DIM_10) || (d == DIM_12) || (d == DIM_16);
  endfunction

endpackage

// File: rtl/bil_row_packer.sv
// Packs a raster pixel stream into one row word; column c lands on bit c.
// Latency: combinational row word / row-complete flag on the last pixel's handshake.
// Backpressure: none of its own; advances only on pix_fire from the parent.
//
// Ports:
//   clk, reset_b : clock, synchronous active-high reset
//   clr          : discard any partial row and restart at column 0
//   pix_fire     : a pixel handshake happens this cycle
//   pix_data     : pixel value for the current column
//   dim          : image dimension N (columns per row)
//   row_last     : pix_fire on column N-1 (row-complete pulse)
//   row_word     : packed row including the current pixel, bits [DATA_W-1:N] zero
module bil_row_packer
  import bin_image_loader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              clr,
  input  logic              pix_fire,
  input  logic              pix_data,
  input  logic [DIM_W-1:0]  dim,
  output logic              row_last,
  output logic [DATA_W-1:0] row_word
);

  localparam int CW = $clog2(DATA_W);

  logic [CW-1:0]     col_q;
  logic [DATA_W-1:0] shift_q;
  logic [DIM_W-1:0]  dim_m1;
  logic [DATA_W-1:0] mask;

  assign dim_m1   = dim - DIM_W'(1);
  assign row_last = pix_fire && (DIM_W'(col_q) == dim_m1);

  // The row word includes the pixel being accepted now, so the parent can
  // register it on the same edge the last pixel is taken.
  always_comb begin
    row_word = shift_q;
    row_word[col_q] = pix_data;
    for (int i = 0; i < DATA_W; i++) begin
      mask[i] = (i < int'(dim));
    end
    row_word = row_word & mask;
  end

  always_ff @(posedge clk) begin
    if (reset_b || clr) begin
      col_q   <= '0;
      shift_q <= '0;
    end else if (pix_fire) begin
      if (row_last) begin
        col_q   <= '0;
        shift_q <= '0;
      end else begin
        col_q          <= col_q + CW'(1);
        shift_q[col_q] <= pix_data;
      end
    end
  end

endmodule

// File: rtl/bin_image_loader.sv
// Writes binary images into the accelerator input SRAM: dim word, N row words per image, terminator.
// Latency: each SRAM write appears one cycle after its triggering cmd/pixel handshake.
// Backpressure: cmd_ready only in CMD, pix_ready only in ROW; pix_ready stays high across row boundaries.
//
// Ports:
//   clk, reset_b                     : clock, synchronous active-high reset
//   ldr_run                          : start pulse (ignored while busy)
//   ldr_busy / ldr_done              : run in progress / one-cycle completion pulse
//   ldr_err                          : one-cycle pulse on an illegal dimension command
//   ldr_ovf                          : sticky address-wrap flag, cleared by reset or run
//   cmd_valid/ready, cmd_last, cmd_dim: image command stream
//   pix_valid/ready, pix_data        : raster pixel stream
//   ldr_sram_write_*                 : registered SRAM write port
module bin_image_loader
  import bin_image_loader_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter int                DATA_W    = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [DATA_W-1:0] TERM_WORD = DATA_W'(TERM_WORD_DEF)
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              ldr_run,
  output logic              ldr_busy,
  output logic              ldr_done,
  output logic              ldr_err,
  output logic              ldr_ovf,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_last,
  input  logic [DIM_W-1:0]  cmd_dim,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic              pix_data,
  output logic [ADDR_W-1:0] ldr_sram_write_address,
  output logic [DATA_W-1:0] ldr_sram_write_data,
  output logic              ldr_sram_write_enable
);

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [DIM_W-1:0]  dim_q;
  logic [DIM_W-1:0]  row_q;

  logic run_go, cmd_fire, pix_fire;
  logic hdr_go, bad_go, term_go, row_go;
  logic img_last;
  logic row_last;
  logic [DATA_W-1:0] row_word;

  // Handshake decodes
  assign run_go   = state_q[IDLE_B] && ldr_run;
  assign cmd_fire = cmd_valid && cmd_ready;
  assign pix_fire = pix_valid && pix_ready;
  assign hdr_go   = cmd_fire && !cmd_last && dim_legal(cmd_dim);
  assign bad_go   = cmd_fire && !cmd_last && !dim_legal(cmd_dim);
  assign term_go  = cmd_fire && cmd_last;
  assign row_go   = row_last;
  assign img_last = (row_q == dim_q - DIM_W'(1));

  bil_row_packer #(
    .DATA_W (DATA_W)
  ) u_row_packer (
    .clk      (clk),
    .reset_b  (reset_b),
    .clr      (run_go || hdr_go),
    .pix_fire (pix_fire),
    .pix_data (pix_data),
    .dim      (dim_q),
    .row_last (row_last),
    .row_word (row_word)
  );

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset_b) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (ldr_run) state_d = ST_CMD;
      ST_CMD: begin
        if (term_go)     state_d = ST_FIN;
        else if (hdr_go) state_d = ST_ROW;
      end
      ST_ROW:  if (row_go && img_last) state_d = ST_CMD;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs. Each ready is a single one-hot state flop bit.
  always_comb begin
    cmd_ready = state_q[CMD_B];
    pix_ready = state_q[ROW_B];
  end

  // Datapath and registered status/SRAM outputs. The write triggers
  // (header, row, terminator) come from mutually exclusive states, so
  // at most one fires per cycle.
  always_ff @(posedge clk) begin
    if (reset_b) begin
      addr_q                 <= BASE_ADDR;
      dim_q                  <= '0;
      row_q                  <= '0;
      ldr_busy               <= 1'b0;
      ldr_done               <= 1'b0;
      ldr_err                <= 1'b0;
      ldr_ovf                <= 1'b0;
      ldr_sram_write_address <= '0;
      ldr_sram_write_data    <= '0;
      ldr_sram_write_enable  <= 1'b0;
    end else begin
      ldr_sram_write_enable <= 1'b0;
      ldr_done              <= 1'b0;
      ldr_err               <= bad_go;

      if (run_go) begin
        addr_q   <= BASE_ADDR;
        ldr_ovf  <= 1'b0;
        ldr_busy <= 1'b1;
      end

      // FIN is the terminator write cycle; busy/done change one cycle later.
      if (state_q[FIN_B]) begin
        ldr_busy <= 1'b0;
        ldr_done <= 1'b1;
      end

      if (hdr_go || term_go || row_go) begin
        ldr_sram_write_enable  <= 1'b1;
        ldr_sram_write_address <= addr_q;
        addr_q                 <= addr_q + ADDR_W'(1);
        if (&addr_q) ldr_ovf <= 1'b1;
        if (term_go)     ldr_sram_write_data <= TERM_WORD;
        else if (hdr_go) ldr_sram_write_data <= DATA_W'(cmd_dim);
        else             ldr_sram_write_data <= row_word;
      end

      if (hdr_go) begin
        dim_q <= cmd_dim;
        row_q <= '0;
      end else if (row_go) begin
        row_q <= row_q + DIM_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_bin_image_loader.sv
// Scoreboard bench for bin_image_loader: drivers push expected SRAM writes, a monitor pops and compares.
// Latency: expects each write one cycle after its handshake, done one cycle after the terminator.
// Backpressure: drivers hold valid until ready is observed; pix_ready stalls inside an image are counted.
module tb_bin_image_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_b, run_a, run_b, cmd_valid, cmd_last, pix_valid, pix_data;
  logic [4:0] cmd_dim;

  logic        busy_a, done_a, err_a, ovf_a, cmd_ready_a, pix_ready_a, we_a;
  logic [11:0] wa_a;
  logic [15:0] wd_a;
  logic        busy_b, done_b, err_b, ovf_b, cmd_ready_b, pix_ready_b, we_b;
  logic [11:0] wa_b;
  logic [15:0] wd_b;

  bin_image_loader u_a (
    .clk(clk), .reset_b(reset_b), .ldr_run(run_a), .ldr_busy(busy_a), .ldr_done(done_a),
    .ldr_err(err_a), .ldr_ovf(ovf_a), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_a),
    .cmd_last(cmd_last), .cmd_dim(cmd_dim), .pix_valid(pix_valid), .pix_ready(pix_ready_a),
    .pix_data(pix_data), .ldr_sram_write_address(wa_a), .ldr_sram_write_data(wd_a),
    .ldr_sram_write_enable(we_a)
  );

  bin_image_loader #(.BASE_ADDR(12'hFFE)) u_b (
    .clk(clk), .reset_b(reset_b), .ldr_run(run_b), .ldr_busy(busy_b), .ldr_done(done_b),
    .ldr_err(err_b), .ldr_ovf(ovf_b), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_b),
    .cmd_last(cmd_last), .cmd_dim(cmd_dim), .pix_valid(pix_valid), .pix_ready(pix_ready_b),
    .pix_data(pix_data), .ldr_sram_write_address(wa_b), .ldr_sram_write_data(wd_b),
    .ldr_sram_write_enable(we_b)
  );

  typedef struct packed {
    logic [11:0] a;
    logic [15:0] d;
    logic        term;
  } wr_t;

  wr_t q_a[$];
  wr_t q_b[$];
  int n_checks = 0;
  int n_err = 0;
  int done_cnt_a = 0, done_cnt_b = 0, err_cnt = 0;
  logic sel = 1'b0;
  logic [11:0] nxt_a = '0, nxt_b = '0;

  wire cmd_rdy_s = sel ? cmd_ready_b : cmd_ready_a;
  wire pix_rdy_s = sel ? pix_ready_b : pix_ready_a;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [15:0] d, input logic term);
    wr_t e;
    e.d = d;
    e.term = term;
    if (!sel) begin
      e.a = nxt_a; q_a.push_back(e); nxt_a = nxt_a + 12'd1;
    end else begin
      e.a = nxt_b; q_b.push_back(e); nxt_b = nxt_b + 12'd1;
    end
  endtask

  function automatic logic pbit(input int kind, input int r, input int c);
    case (kind)
      0:       return 1'b1;
      1:       return ((r + c + 1) % 2) != 0;
      2:       return r == c;
      default: return ((r * 3 + c) % 5) == 0;
    endcase
  endfunction

  // Monitor: compare every SRAM write against the expected queue; check the
  // done/busy edge right after each terminator write.
  wr_t m_e;
  logic term_prev_a = 1'b0, term_prev_b = 1'b0;
  always @(negedge clk) begin
    if (reset_b) begin
      term_prev_a = 1'b0;
      term_prev_b = 1'b0;
    end else begin
      if (term_prev_a) begin
        chk("done_a_after_term", done_a, 1);
        chk("busy_a_after_term", busy_a, 0);
      end else if (done_a) chk("done_a_spurious", done_a, 0);
      term_prev_a = 1'b0;
      if (we_a) begin
        if (q_a.size() == 0) chk("unexpected_write_a", we_a, 0);
        else begin
          m_e = q_a.pop_front();
          chk("addr_a", wa_a, m_e.a);
          chk("data_a", wd_a, m_e.d);
          term_prev_a = m_e.term;
        end
      end
      if (term_prev_b) begin
        chk("done_b_after_term", done_b, 1);
        chk("busy_b_after_term", busy_b, 0);
      end else if (done_b) chk("done_b_spurious", done_b, 0);
      term_prev_b = 1'b0;
      if (we_b) begin
        if (q_b.size() == 0) chk("unexpected_write_b", we_b, 0);
        else begin
          m_e = q_b.pop_front();
          chk("addr_b", wa_b, m_e.a);
          chk("data_b", wd_b, m_e.d);
          term_prev_b = m_e.term;
        end
      end
      if (err_a || err_b) err_cnt++;
      if (done_a) done_cnt_a++;
      if (done_b) done_cnt_b++;
    end
  end

  task automatic do_run();
    if (!sel) begin run_a = 1'b1; nxt_a = 12'h000; end
    else      begin run_b = 1'b1; nxt_b = 12'hFFE; end
    tick();
    run_a = 1'b0;
    run_b = 1'b0;
    chk("busy_after_run", sel ? busy_b : busy_a, 1);
  endtask

  task automatic send_cmd(input logic last, input logic [4:0] dim);
    logic acc;
    int n;
    cmd_valid = 1'b1; cmd_last = last; cmd_dim = dim;
    if (last) push_wr(16'h00FF, 1'b1);
    else if (dim == 5'd10 || dim == 5'd12 || dim == 5'd16) push_wr({11'd0, dim}, 1'b0);
    n = 0;
    forever begin
      @(negedge clk);
      acc = cmd_rdy_s;
      tick();
      if (acc) break;
      n++;
      if (n > 50) begin chk("cmd_accept_timeout", acc, 1); break; end
    end
    cmd_valid = 1'b0; cmd_last = 1'b0;
  endtask

  task automatic send_image(input int dim, input int kind, input bit bubbles, input int abort_at);
    logic acc;
    logic [15:0] w;
    int n, idx, stalls;
    idx = 0;
    stalls = 0;
    for (int r = 0; r < dim; r++) begin
      w = '0;
      for (int c = 0; c < dim; c++) begin
        if (bubbles) begin
          pix_valid = 1'b0;
          repeat ($urandom_range(0, 2)) tick();
        end
        pix_data = pbit(kind, r, c);
        pix_valid = 1'b1;
        if (idx == abort_at) begin
          reset_b = 1'b1;
          tick();
          reset_b = 1'b0;
          pix_valid = 1'b0;
          chk("abort_we", we_a, 0);
          chk("abort_busy", busy_a, 0);
          chk("abort_pix_ready", pix_ready_a, 0);
          chk("abort_queue", q_a.size(), 0);
          return;
        end
        n = 0;
        forever begin
          @(negedge clk);
          acc = pix_rdy_s;
          tick();
          if (acc) break;
          stalls++;
          n++;
          if (n > 50) begin chk("pix_accept_timeout", acc, 1); pix_valid = 1'b0; return; end
        end
        w[c] = pix_data;
        if (c == dim - 1) push_wr(w, 1'b0);
        idx++;
      end
    end
    pix_valid = 1'b0;
    chk("pix_stalls_in_image", stalls, 0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0 || busy_a || busy_b) && n < 100) begin
      tick();
      n++;
    end
    chk("drain_queues", q_a.size() + q_b.size(), 0);
    tick();
  endtask

  initial begin
    reset_b = 1'b1; run_a = 1'b0; run_b = 1'b0;
    cmd_valid = 1'b0; cmd_last = 1'b0; cmd_dim = '0;
    pix_valid = 1'b0; pix_data = 1'b0;
    repeat (3) tick();
    chk("rst_we", we_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_cmd_ready", cmd_ready_a, 0);
    chk("rst_pix_ready", pix_ready_a, 0);
    chk("rst_addr", wa_a, 0);
    chk("rst_data", wd_a, 0);
    reset_b = 1'b0;
    tick();

    // 10x10 all ones: 0x000A, 10 x 0x03FF, 0x00FF at 11
    sel = 1'b0;
    do_run();
    send_cmd(1'b0, 5'd10);
    send_image(10, 0, 1'b0, -1);
    send_cmd(1'b1, 5'd0);
    wait_idle();

    // 16x16 checkerboard, with ldr_run held high while busy (must be ignored)
    do_run();
    send_cmd(1'b0, 5'd16);
    run_a = 1'b1;
    send_image(16, 1, 1'b0, -1);
    run_a = 1'b0;
    send_cmd(1'b1, 5'd0);
    wait_idle();

    // back-to-back 12 then 10
    do_run();
    send_cmd(1'b0, 5'd12);
    send_image(12, 2, 1'b0, -1);
    send_cmd(1'b0, 5'd10);
    send_image(10, 3, 1'b0, -1);
    send_cmd(1'b1, 5'd0);
    wait_idle();

    // illegal dimension, then a normal image from BASE_ADDR
    do_run();
    send_cmd(1'b0, 5'd11);
    chk("err_pulse", err_a, 1);
    chk("no_write_on_err", we_a, 0);
    chk("cmd_ready_after_err", cmd_ready_a, 1);
    send_cmd(1'b0, 5'd10);
    send_image(10, 0, 1'b0, -1);
    send_cmd(1'b1, 5'd0);
    wait_idle();

    // 12x12 with random pix_valid bubbles
    do_run();
    send_cmd(1'b0, 5'd12);
    send_image(12, 2, 1'b1, -1);
    send_cmd(1'b1, 5'd0);
    wait_idle();

    // reset on pixel 37 of a 16x16 image, then a fresh run
    do_run();
    send_cmd(1'b0, 5'd16);
    send_image(16, 1, 1'b0, 36);
    tick();
    do_run();
    send_cmd(1'b0, 5'd10);
    send_image(10, 3, 1'b0, -1);
    send_cmd(1'b1, 5'd0);
    wait_idle();

    // BASE_ADDR=0xFFE instance: addresses wrap to 0x000 and ovf sets
    sel = 1'b1;
    do_run();
    chk("ovf_b_clear_after_run", ovf_b, 0);
    send_cmd(1'b0, 5'd10);
    send_image(10, 2, 1'b0, -1);
    send_cmd(1'b1, 5'd0);
    wait_idle();
    chk("ovf_b_after_wrap", ovf_b, 1);
    chk("ovf_a_no_wrap", ovf_a, 0);

    chk("err_pulse_count", err_cnt, 1);
    chk("done_count_a", done_cnt_a, 6);
    chk("done_count_b", done_cnt_b, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    n_checks++;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
